cmsdk_uart_stimulus: RTL and testbench

Testbench-side UART transmitter for the Cortex-M0 example system: the opposite end of the UART capture path. It accepts bytes from a bench sequencer through a valid/ready handshake, buffers them in a small FIFO, and serialises them as 8N1 frames onto an MCU UART RXD pin (P1[0]). Its bit timing matches the capture device, so the same CLK (PCLK = XTAL1) drives both.

---
 rtl/cmsdk_uart_stimulus.sv | 145 ++++++++++++++
 tb/tb_cmsdk_uart_stimulus.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmsdk_uart_stimulus.sv
// Bench-side 8N1 UART transmitter: bytes arrive over valid/ready, queue in a small FIFO
// and are serialised LSB first onto TXD with BAUD_DIV clocks per bit.
module cmsdk_uart_stimulus #(
  parameter int BAUD_DIV   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  output logic       TXD,
  output logic       BUSY,
  output logic       TX_DONE
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LP_TC     = 16'(BAUD_DIV - 1);
  localparam logic [15:0] LP_PRE_TC = 16'((BAUD_DIV >= 2) ? BAUD_DIV - 2 : 0);
  localparam logic [AW:0] LP_FULL   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ready;
  logic [15:0]   r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_tx_done;

  logic          w_push;
  logic          w_pop;
  logic          w_baud_tc;
  logic          w_fifo_empty;
  logic [AW:0]   w_count_nxt;

  assign w_push       = DATA_VALID && r_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_baud_tc    = (r_baud == LP_TC);
  assign w_pop        = !w_fifo_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_tc));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) w_count_nxt = r_count + 1'b1;
    if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= DATA_IN;
  end

  // Ready is registered from the next count, so a pop cannot open a slot in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != LP_FULL);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_txd  <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= S_START;
            r_txd   <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_tc) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_txd     <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_tc) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
              if (BAUD_DIV == 1) r_tx_done <= 1'b1;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          // TX_DONE is registered, so it is raised one edge ahead of the final stop cycle.
          if (w_baud_tc) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= S_START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
            if ((BAUD_DIV >= 2) && (r_baud == LP_PRE_TC)) r_tx_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DATA_READY = r_ready;
  assign TXD        = r_txd;
  assign TX_DONE    = r_tx_done;
  assign BUSY       = (r_state != S_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_cmsdk_uart_stimulus.sv
// Bench for cmsdk_uart_stimulus: two instances (BAUD_DIV 1 and 16), a scoreboard queue per
// instance filled on accepted pushes and drained by a serial-line capture monitor.
module tb_cmsdk_uart_stimulus;

  logic       clk;
  logic [1:0] rst;
  logic [1:0] valid;
  logic [1:0] ready;
  logic [1:0] txd;
  logic [1:0] busy;
  logic [1:0] done;
  logic [7:0] din [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int frames [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  cmsdk_uart_stimulus #(.BAUD_DIV(1), .FIFO_DEPTH(4)) u_dut1 (
    .CLK(clk), .RESET(rst[0]), .DATA_IN(din[0]), .DATA_VALID(valid[0]),
    .DATA_READY(ready[0]), .TXD(txd[0]), .BUSY(busy[0]), .TX_DONE(done[0])
  );

  cmsdk_uart_stimulus #(.BAUD_DIV(16), .FIFO_DEPTH(4)) u_dut16 (
    .CLK(clk), .RESET(rst[1]), .DATA_IN(din[1]), .DATA_VALID(valid[1]),
    .DATA_READY(ready[1]), .TXD(txd[1]), .BUSY(busy[1]), .TX_DONE(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_n(input int k, input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst[k] !== 1'b0) ab = 1'b1;
    end
  endtask

  // Capture model: samples each bit mid-period, then checks against the scoreboard.
  task automatic monitor(input int k, input int div);
    logic [7:0] b;
    logic [7:0] e;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst[k] === 1'b0 && txd[k] === 1'b0) begin
        ab = 1'b0;
        b  = '0;
        wait_n(k, div / 2, ab);
        if (!ab) check($sformatf("start_bit%0d", k), txd[k], 0);
        for (int i = 0; i < 8 && !ab; i++) begin
          wait_n(k, div, ab);
          b[i] = txd[k];
        end
        if (!ab) wait_n(k, div, ab);
        if (!ab) check($sformatf("stop_bit%0d", k), txd[k], 1);
        if (!ab) wait_n(k, div - div / 2 - 1, ab);
        if (!ab) begin
          check($sformatf("tx_done_last_stop%0d", k), done[k], 1);
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_frame%0d", k), {24'd0, b}, 32'hFFFF_FFFF);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rx_byte%0d", k), b, e);
            frames[k]++;
          end
        end
      end
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    valid[k] = 1'b1;
    din[k]   = d;
    for (int t = 0; t < 300 && !acc; t++) begin
      if (ready[k]) begin
        @(posedge clk);
        acc = 1'b1;
        if (k == 0) q0.push_back(d);
        else        q1.push_back(d);
      end else begin
        @(negedge clk);
      end
    end
    if (!acc) check($sformatf("push_accept%0d", k), 0, 1);
  endtask

  task automatic release_valid(input int k);
    @(negedge clk);
    valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int budget, input string name);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy[k] === 1'b0) break;
    end
    check(name, busy[k], 0);
  endtask

  initial begin
    int seq55 [10];
    int t0;
    int t1;
    int ndone;
    int fbase;
    int gap;
    bit saw_full;

    seq55  = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    rst    = 2'b11;
    valid  = 2'b11;
    din[0] = 8'hFF;
    din[1] = 8'hFF;
    frames[0] = 0;
    frames[1] = 0;
    fork
      monitor(0, 1);
      monitor(1, 16);
    join_none

    // Reset held with DATA_VALID high: no line activity, no acceptance.
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rst_txd%0d", k), txd[k], 1);
        check($sformatf("rst_busy%0d", k), busy[k], 0);
        check($sformatf("rst_ready%0d", k), ready[k], 1);
        check($sformatf("rst_done%0d", k), done[k], 0);
      end
    end
    valid = 2'b00;
    rst   = 2'b00;
    repeat (4) @(negedge clk);
    check("post_rst_txd0", txd[0], 1);
    check("post_rst_busy1", busy[1], 0);

    // Single 0x55 at BAUD_DIV=1: exact cycle-by-cycle line pattern.
    push(0, 8'h55);
    release_valid(0);
    check("latency_txd_idle", txd[0], 1);
    check("latency_busy", busy[0], 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("b1_txd_c%0d", i), txd[0], seq55[i]);
      check($sformatf("b1_done_c%0d", i), done[0], (i == 9) ? 1 : 0);
    end
    @(negedge clk);
    check("b1_busy_after", busy[0], 0);
    check("b1_done_after", done[0], 0);

    // 0xA3 at BAUD_DIV=16: 160-cycle frame, decode via monitor.
    push(1, 8'hA3);
    release_valid(1);
    t0 = -1;
    t1 = -1;
    for (int c = 0; c < 400 && t1 < 0; c++) begin
      @(negedge clk);
      if (t0 < 0 && txd[1] === 1'b0) t0 = cyc;
      if (done[1] === 1'b1) t1 = cyc;
    end
    check("b16_frame_len", t1 - t0, 159);
    wait_idle(1, 50, "b16_idle");

    // Back-pressure: six bytes with DATA_VALID held, FIFO_DEPTH=4.
    t0 = -1;
    t1 = -1;
    ndone = 0;
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) push(0, 8'(i));
        @(negedge clk);
        check("bp_ready_full", ready[0], 0);
        saw_full = 1'b1;
        push(0, 8'h05);
        release_valid(0);
      end
      begin
        for (int c = 0; c < 300; c++) begin
          @(negedge clk);
          if (t0 < 0 && txd[0] === 1'b0) t0 = cyc;
          if (done[0] === 1'b1) begin
            ndone++;
            t1 = cyc;
          end
          if (ndone >= 6 && busy[0] === 1'b0) break;
        end
      end
    join
    check("bp_full_seen", saw_full, 1);
    check("bp_done_pulses", ndone, 6);
    check("bp_span", t1 - t0, 59);
    check("bp_queue_empty", q0.size(), 0);

    // Wrap-around: 20 bytes with random valid gaps.
    fbase = frames[0];
    for (int i = 0; i < 20; i++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
      push(0, 8'(i * 37 + 11));
    end
    release_valid(0);
    wait_idle(0, 600, "wrap_idle");
    check("wrap_frames", frames[0] - fbase, 20);
    check("wrap_queue_empty", q0.size(), 0);

    // Reset during data bit 3 of 0x0F, then a clean 0x41 frame.
    push(1, 8'h0F);
    release_valid(1);
    t0 = -1;
    for (int c = 0; c < 50 && t0 < 0; c++) begin
      @(negedge clk);
      if (txd[1] === 1'b0) t0 = cyc;
    end
    check("mid_start_seen", (t0 >= 0) ? 1 : 0, 1);
    repeat (70) @(negedge clk);
    check("mid_bit3_high", txd[1], 1);
    check("mid_busy_pre", busy[1], 1);
    rst[1] = 1'b1;
    #1;
    check("mid_rst_txd", txd[1], 1);
    check("mid_rst_busy", busy[1], 0);
    check("mid_rst_ready", ready[1], 1);
    q1.delete();
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_post_txd", txd[1], 1);
    check("mid_post_busy", busy[1], 0);
    fbase = frames[1];
    push(1, 8'h41);
    release_valid(1);
    wait_idle(1, 400, "mid_idle");
    check("mid_frames", frames[1] - fbase, 1);
    check("mid_queue_empty", q1.size(), 0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
